// File: rtl/camera_stream_decimator.sv
// camera_stream_decimator: 2x2 box-average decimator for an RGB444 pixel stream.
// Each non-overlapping 2x2 input block becomes one output pixel. Horizontal
// pair sums of even rows are parked in a line buffer and combined with the
// pair sums of the following odd row.
// Optional feature macro: DECIMATOR_ROUND_EN (round half up instead of truncate).
module camera_stream_decimator #(
  parameter int IN_WIDTH  = 640,
  parameter int IN_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        startofpacket_in,
  input  logic        endofpacket_in,
  input  logic [11:0] data_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic [11:0] data_out,
  output logic        frame_error
);

  localparam int CW   = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 2;
  localparam int RW   = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int AW   = CW - 1;
  localparam int LB_D = IN_WIDTH / 2;

  logic [CW-1:0] col_q, col_d, col_e;
  logic [RW-1:0] row_q, row_d, row_e;
  logic [11:0]   pair_q;
  logic [14:0]   lb_q [LB_D];
  logic [14:0]   lb_rd_q;
  logic          vld_q, sop_q, eop_q, err_q;
  logic [11:0]   dat_q;

  logic          accept, at_last, odd_col, odd_row, load, err_set;
  logic [AW-1:0] addr;

  logic [2:0][4:0] sum5;
  logic [2:0][5:0] sum6;
  logic [2:0][3:0] avg;

  assign accept  = valid_in && ready_in;
  // sop forces the pixel to (0,0) before any other decision is made
  assign col_e   = startofpacket_in ? '0 : col_q;
  assign row_e   = startofpacket_in ? '0 : row_q;
  assign at_last = (col_e == CW'(IN_WIDTH - 1)) && (row_e == RW'(IN_HEIGHT - 1));
  assign odd_col = col_e[0];
  assign odd_row = row_e[0];
  assign addr    = col_e[CW-1:1];
  assign load    = accept && odd_row && odd_col;
  // eop must coincide exactly with the last pixel; a restart away from (0,0) is an error
  assign err_set = (startofpacket_in && (col_q != '0 || row_q != '0)) ||
                   (endofpacket_in != at_last);

  // Per-channel arithmetic: pair sum, block sum, reduction to 4 bits
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign sum5[c] = {1'b0, pair_q[4*c +: 4]} + {1'b0, data_in[4*c +: 4]};
    assign sum6[c] = {1'b0, sum5[c]} + {1'b0, lb_rd_q[5*c +: 5]};
`ifdef DECIMATOR_ROUND_EN
    logic [5:0] rnd;
    assign rnd    = sum6[c] + 6'd2;
    assign avg[c] = rnd[5:2];
`else
    assign avg[c] = sum6[c][5:2];
`endif
  end

  // Next raster position after the accepted pixel
  always_comb begin
    col_d = col_e + CW'(1);
    row_d = row_e;
    if (col_e == CW'(IN_WIDTH - 1)) begin
      col_d = '0;
      row_d = (row_e == RW'(IN_HEIGHT - 1)) ? '0 : row_e + RW'(1);
    end
  end

  // Position counters, even-column pair latch and sticky framing error
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
      if (!odd_col) pair_q <= data_in;
      if (err_set)  err_q  <= 1'b1;
    end
  end

  // Line buffer: written on even rows; read one pixel early on odd rows so the
  // entry is waiting in lb_rd_q when the pair completes (no bubble at row turn)
  always_ff @(posedge clk) begin
    if (accept && !odd_row && odd_col) lb_q[addr] <= sum5;
    if (accept && odd_row && !odd_col) lb_rd_q    <= lb_q[addr];
  end

  // Single-entry output register; load may coincide with a drain
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      dat_q <= '0;
    end else if (load) begin
      vld_q <= 1'b1;
      sop_q <= (col_e == CW'(1)) && (row_e == RW'(1));
      eop_q <= at_last;
      dat_q <= avg;
    end else if (vld_q && ready_out) begin
      vld_q <= 1'b0;
    end
  end

  // Stall input whenever the held output cannot leave this cycle
  assign ready_in          = !(vld_q && !ready_out);
  assign valid_out         = vld_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out   = eop_q;
  assign data_out          = dat_q;
  assign frame_error       = err_q;

endmodule
